priority_req_scheduler: RTL and testbench
=========================================

// Module: priority_req_scheduler
// PURPOSE
//  Control stage wrapped around priority_mux_6to1. Latches request pulses from five sources,
//  drives the mux sel input with a one-hot grant for the highest pending source, and captures
//  the mux d_out into a registered output word. Presents each word downstream with a
//  valid/ready handshake. One word per granted request; d0 is the idle/default input (sel=0).
// PARAMETERS
//  DW    8  data width of mux d_out and out_data
//  NSRC  5  number of requesters; equals mux sel width; fixed at 5 for priority_mux_6to1
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-high reset
//  req_in    in   NSRC   request pulses; bit k requests the mux input d(k+1); bit 4 has highest priority
//  sel       out  NSRC   to mux sel; 0 or one-hot grant
//  mux_dout  in   DW     from mux d_out
//  out_data  out  DW     captured word
//  out_src   out  3      source of out_data: 1..5 = d1..d5
//  out_valid out  1      out_data/out_src valid
//  out_ready in   1      downstream accepts when out_valid && out_ready
//  pending   out  NSRC   outstanding request bits
//  overflow  out  1      sticky flag: a request was lost
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; sel, pending, out_data, out_src, out_valid, overflow = 0.
//  pending[k] is set on any rising edge where req_in[k]=1. It is cleared only on the accept
//   edge of a word from source k.
//  If req_in[k]=1 on the same edge that source k is accepted, pending[k] stays 1 and source k
//   is serviced again.
//  overflow is set (sticky until rst) when req_in[k]=1, pending[k]=1, and pending[k] is not
//   being cleared on that edge.
//  FSM states: IDLE, SEL, HOLD. All outputs are registered.
//   IDLE: sel=0 and out_valid=0. If pending!=0, the block latches grant = one-hot of the highest
//    set bit of pending, sets sel<=grant and goes to SEL. Requests arriving in the same cycle
//    are not yet visible to pending.
//   SEL: sel is held. The block captures out_data<=mux_dout and out_src<=k+1, sets out_valid<=1
//    and goes to HOLD. The mux is combinational, so one cycle of settling is sufficient.
//   HOLD: sel, out_data, out_src and out_valid are held stable while out_ready=0. When
//    out_ready=1, the block clears out_valid, clears pending[k] (subject to the re-request
//    rule) and sel, then returns to IDLE.
//  The grant is locked from IDLE exit until acceptance. A higher-priority request arriving
//   during SEL or HOLD does not preempt; it is only marked pending.
//  Latency: req_in high in cycle n, with the block in IDLE and pending=0, gives sel valid in
//   cycle n+2 and out_valid in cycle n+3.
//  Throughput: at most one word per 3 cycles (HOLD->IDLE->SEL->HOLD). No combinational path
//   from out_ready to out_valid.
//  Reset in mid-operation: all requests in flight are dropped and out_valid falls
//   asynchronously. After rst is released, no word is issued until a new req_in arrives.
// TESTING
//  Use mux inputs d0=B8 d1=F0 d2=55 d3=33 d4=E3 d5=AA. Check the reset values after every
//  test. Score all mismatches to error_count and print the total at the end of the run.
//  1 Reset: assert rst at any state -> sel=00000, out_valid=0, pending=0, overflow=0 in the
//    same cycle.
//  2 Single request: req_in=00001 for 1 cycle, out_ready=1 -> sel=00001 at n+2; out_valid=1 at
//    n+3 with out_data=F0 and out_src=1; then pending=0.
//  3 Priority order: req_in=10101 for 1 cycle, out_ready=1 -> words AA/5, 33/3, F0/1 in that
//    order; sel goes 10000, 00100, 00001; 3 cycles apart.
//  4 Backpressure and no preemption: req_in=00010, out_ready=0 for 10 cycles, plus req_in=01000
//    during HOLD -> out_data=55 and sel=00010 are held stable. After out_ready=1, the next word
//    is E3/4.
//  5 Overflow: req_in=00100 twice while pending[2]=1 -> overflow=1 (sticky); exactly one word 33
//    is output.
//  6 Re-request on accept: req_in=00001 on the accept edge of source 1 -> a second F0/1 word is
//    output.

Source files
------------

// File: rtl/priority_req_scheduler.sv
// priority_req_scheduler
//   Control stage around a 6:1 priority mux. Request pulses from NSRC sources are latched
//   into a pending vector. The highest pending source is granted a one-hot mux select.
//   The mux output is then captured into a registered word, which is presented downstream
//   with a valid/ready handshake.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_in     request pulses, bit k selects mux input d(k+1); bit NSRC-1 has highest priority
//   sel        one-hot grant to the mux select (0 selects the idle input d0)
//   mux_dout   combinational mux output
//   out_data   captured word
//   out_src    source of out_data, 1..NSRC
//   out_valid  out_data/out_src valid
//   out_ready  downstream accept
//   pending    outstanding request bits
//   overflow   sticky: a request hit an already pending source and was lost
module priority_req_scheduler #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NSRC = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req_in,
  output logic [NSRC-1:0] sel,
  input  logic [DW-1:0]   mux_dout,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NSRC-1:0] pending,
  output logic            overflow
);

  typedef enum logic [1:0] {StIdle, StSel, StHold} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] sel_q, sel_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [2:0]      out_src_q, out_src_d;
  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d;

  logic [2:0]      grant_idx;
  logic [NSRC-1:0] grant_oh;
  logic [2:0]      sel_src;
  logic            accept;
  logic [NSRC-1:0] clr;

  // Highest set bit of pending; later iterations override earlier ones.
  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (pending_q[k]) grant_idx = 3'(k);
    end
    grant_oh = NSRC'(1) << grant_idx;
  end

  // Source number (1-based) of the locked grant.
  always_comb begin
    sel_src = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_q[k]) sel_src = 3'(k + 1);
    end
  end

  assign accept = (state_q == StHold) && out_ready;
  assign clr    = accept ? sel_q : '0;

  // A request on the accept edge of its own source survives the clear and re-arms it.
  assign pending_d  = (pending_q & ~clr) | req_in;
  assign overflow_d = overflow_q | (|(req_in & pending_q & ~clr));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) begin
          sel_d   = grant_oh;
          state_d = StSel;
        end
      end
      StSel: begin
        // The mux has had the full SEL cycle to settle on the new select.
        out_data_d  = mux_dout;
        out_src_d   = sel_src;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          sel_d       = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        sel_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      pending_q   <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sel       = sel_q;
  assign pending   = pending_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_priority_req_scheduler.sv
// Bench for priority_req_scheduler: directed scenarios with literal expectations, then
// randomized traffic, all continuously compared against a transaction-level model.
module tb_priority_req_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_in;
  logic [4:0] sel;
  logic [7:0] mux_dout;
  logic [7:0] out_data;
  logic [2:0] out_src;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] pending;
  logic       overflow;

  logic [7:0] dval [0:5] = '{8'hB8, 8'hF0, 8'h55, 8'h33, 8'hE3, 8'hAA};

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  priority_req_scheduler #(.DW(8), .NSRC(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .sel      (sel),
    .mux_dout (mux_dout),
    .out_data (out_data),
    .out_src  (out_src),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // priority_mux_6to1: highest set sel bit wins, d0 when sel is zero.
  always_comb begin
    mux_dout = dval[0];
    for (int k = 0; k < 5; k++) begin
      if (sel[k]) mux_dout = dval[k + 1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  // Model: a grant is picked one cycle after a source becomes pending, the word appears one
  // cycle later and stays until accepted.
  logic [4:0] m_pend, m_old;
  bit         m_ovf, m_valid, m_acc;
  int         m_grant, m_step, m_src;
  logic [7:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_ovf = 0; m_valid = 0; m_grant = 0; m_step = 0; m_src = 0; m_data = '0;
    end else begin
      m_old = m_pend;
      m_acc = m_valid && out_ready;
      for (int k = 0; k < 5; k++) begin
        if (req_in[k] && m_pend[k] && !(m_acc && m_src == k + 1)) m_ovf = 1;
      end
      if (m_acc) m_pend[m_src - 1] = 1'b0;
      m_pend = m_pend | req_in;
      if (m_acc) begin
        m_valid = 0; m_grant = 0; m_step = 0;
      end else if (m_step == 1) begin
        m_data = dval[m_grant]; m_src = m_grant; m_valid = 1; m_step = 2;
      end else if (m_step == 0 && m_old != '0) begin
        for (int k = 0; k < 5; k++) if (m_old[k]) m_grant = k + 1;
        m_step = 1;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Continuous compare and accepted-word monitor, away from the active edge.
  int q_data[$], q_src[$], q_cyc[$];
  always @(negedge clk) begin
    if (!rst) begin
      chk("sel", 32'(sel), (m_grant != 0) ? 32'(1 << (m_grant - 1)) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
      end
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_src.push_back(int'(out_src));
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset mid-cycle, check outputs cleared immediately, release off-edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    req_in    = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    q_data.delete(); q_src.delete(); q_cyc.delete();
  endtask

  initial begin
    rst       = 1'b1;
    req_in    = '0;
    out_ready = 1'b0;
    tick(2);
    do_reset();

    // Single request latency.
    out_ready = 1'b1;
    req_in = 5'b00001; tick();
    req_in = '0;       tick();
    chk("t2_sel_n2", 32'(sel), 32'b00001);
    chk("t2_valid_n2", 32'(out_valid), 32'd0);
    tick();
    chk("t2_valid_n3", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hF0);
    chk("t2_src", 32'(out_src), 32'd1);
    tick();
    chk("t2_pending", 32'(pending), 32'd0);
    do_reset();

    // Priority order and 3-cycle spacing.
    out_ready = 1'b1;
    req_in = 5'b10101; tick();
    req_in = '0;       tick(14);
    chk("t3_count", 32'(q_data.size()), 32'd3);
    if (q_data.size() >= 3) begin
      chk("t3_w0", 32'((q_data[0] << 4) | q_src[0]), 32'hAA5);
      chk("t3_w1", 32'((q_data[1] << 4) | q_src[1]), 32'h333);
      chk("t3_w2", 32'((q_data[2] << 4) | q_src[2]), 32'hF01);
      chk("t3_gap1", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
      chk("t3_gap2", 32'(q_cyc[2] - q_cyc[1]), 32'd3);
    end
    do_reset();

    // Backpressure, no preemption.
    req_in = 5'b00010; tick();
    req_in = '0;       tick(2);
    req_in = 5'b01000; tick();
    req_in = '0;       tick(9);
    chk("t4_data", 32'(out_data), 32'h55);
    chk("t4_sel", 32'(sel), 32'b00010);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_pending", 32'(pending), 32'b01010);
    out_ready = 1'b1;  tick(8);
    chk("t4_count", 32'(q_data.size()), 32'd2);
    if (q_data.size() >= 2) begin
      chk("t4_w0", 32'((q_data[0] << 4) | q_src[0]), 32'h552);
      chk("t4_w1", 32'((q_data[1] << 4) | q_src[1]), 32'hE34);
    end
    do_reset();

    // Overflow: lost requests, single word.
    req_in = 5'b00100; tick();
    req_in = '0;       tick();
    req_in = 5'b00100; tick(2);
    req_in = '0;       tick();
    chk("t5_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;  tick(8);
    chk("t5_count", 32'(q_data.size()), 32'd1);
    if (q_data.size() >= 1) chk("t5_w0", 32'(q_data[0]), 32'h33);
    chk("t5_sticky", 32'(overflow), 32'd1);
    do_reset();

    // Re-request on the accept edge.
    req_in = 5'b00001; tick();
    req_in = '0;       tick(2);
    req_in = 5'b00001; out_ready = 1'b1; tick();
    req_in = '0;       tick(8);
    chk("t6_count", 32'(q_data.size()), 32'd2);
    if (q_data.size() >= 2) begin
      chk("t6_w0", 32'((q_data[0] << 4) | q_src[0]), 32'hF01);
      chk("t6_w1", 32'((q_data[1] << 4) | q_src[1]), 32'hF01);
    end
    chk("t6_overflow", 32'(overflow), 32'd0);
    do_reset();

    // Randomized traffic with occasional mid-operation resets.
    for (int i = 0; i < 2000; i++) begin
      req_in    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
    end
    req_in = '0;
    out_ready = 1'b1;
    tick(40);
    do_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
